// File: rtl/spi_cmd_handler_if.sv
// Byte-in / frame-out bus between the SPI slave shifter and the command
// handler. The shifter (or a bench standing in for it) is the master side.
interface spi_cmd_handler_if;
  logic [7:0]  i_rx_byte;
  logic        i_rx_tgl;
  logic        i_spi_cs;
  logic [39:0] o_tx_frame;
  logic        o_tx_frame_valid;
  logic        o_busy;
  logic [7:0]  o_err_cnt;

  modport master (
    output i_rx_byte, i_rx_tgl, i_spi_cs,
    input  o_tx_frame, o_tx_frame_valid, o_busy, o_err_cnt
  );

  modport slave (
    input  i_rx_byte, i_rx_tgl, i_spi_cs,
    output o_tx_frame, o_tx_frame_valid, o_busy, o_err_cnt
  );
endinterface

// File: rtl/spi_cmd_handler.sv
// SPI command decoder: brings each received byte across from the SPI clock
// domain via a toggle synchroniser, runs READ_ID / WRITE_REG / READ_REG over
// a small register file and builds the 40-bit frame for the tx shifter.
module spi_cmd_handler #(
  parameter logic [39:0] ID_WORD     = 40'h5925A2B012,
  parameter int          NUM_REGS    = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic clk_12MHz,
  input  logic i_rst_n,
  spi_cmd_handler_if.slave bus
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_ADDR = 2'd1;
  localparam logic [1:0] ST_WR_DATA = 2'd2;
  localparam logic [1:0] ST_RD_ADDR = 2'd3;

  logic [SYNC_STAGES-1:0] tgl_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic                   tgl_prev_reg;
  logic                   cs_prev_reg;
  logic                   byte_evt;
  logic                   cs_rise;

  logic [1:0]  state_reg, state_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  err_reg, err_next;
  logic [39:0] frame_reg, frame_next;
  logic        load_next, load_reg;
  logic        valid_reg;
  logic        busy_reg;
  logic        err_inc;
  logic        wr_en;
  logic [7:0]  rd_data;
  logic        byte_in_range;
  logic        addr_in_range;

  logic [7:0]  regs_reg [NUM_REGS];

  // Synchronise the rx toggle and chip select, and keep the last synced
  // value of each for edge detection.
  always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tgl_sync_reg <= '0;
      cs_sync_reg  <= '0;
      tgl_prev_reg <= 1'b0;
      cs_prev_reg  <= 1'b0;
    end else begin
      tgl_sync_reg <= {tgl_sync_reg[SYNC_STAGES-2:0], bus.i_rx_tgl};
      cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], bus.i_spi_cs};
      tgl_prev_reg <= tgl_sync_reg[SYNC_STAGES-1];
      cs_prev_reg  <= cs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign byte_evt = tgl_sync_reg[SYNC_STAGES-1] ^ tgl_prev_reg;
  assign cs_rise  = cs_sync_reg[SYNC_STAGES-1] & ~cs_prev_reg;

  // The rx byte is stable long after the toggle, so it is used unsynchronised.
  assign byte_in_range = ({1'b0, bus.i_rx_byte} < 9'(NUM_REGS));
  assign addr_in_range = ({1'b0, addr_reg} < 9'(NUM_REGS));
  assign rd_data = byte_in_range ? regs_reg[bus.i_rx_byte[IDX_W-1:0]] : 8'h00;

  // Command FSM: one step per received byte; a CS rise aborts and wins over
  // a byte arriving in the same cycle.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    frame_next = frame_reg;
    load_next  = 1'b0;
    err_inc    = 1'b0;
    wr_en      = 1'b0;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else if (byte_evt) begin
      case (state_reg)
        ST_IDLE: begin
          case (bus.i_rx_byte)
            8'h00: state_next = ST_IDLE;
            8'h01: begin
              frame_next = ID_WORD;
              load_next  = 1'b1;
            end
            8'h02: state_next = ST_WR_ADDR;
            8'h03: state_next = ST_RD_ADDR;
            default: err_inc = 1'b1;
          endcase
        end
        ST_WR_ADDR: begin
          addr_next  = bus.i_rx_byte;
          state_next = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wr_en      = addr_in_range;
          err_inc    = ~addr_in_range;
          state_next = ST_IDLE;
        end
        default: begin
          // Frame carries the error count from before this read's own error.
          frame_next = {8'h03, bus.i_rx_byte, rd_data, err_reg, 8'h00};
          load_next  = 1'b1;
          err_inc    = ~byte_in_range;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign err_next = (err_inc && err_reg != 8'hFF) ? err_reg + 8'd1 : err_reg;

  // Control state, frame, error counter and the delayed frame-valid pulse.
  always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= 8'h00;
      frame_reg <= 40'h0;
      load_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      frame_reg <= frame_next;
      load_reg  <= load_next;
      valid_reg <= load_reg;
      busy_reg  <= (state_next != ST_IDLE);
      err_reg   <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      // One register-file entry, written only by a completed in-range WRITE_REG.
      always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
          regs_reg[gi] <= 8'h00;
        end else if (wr_en && addr_reg[IDX_W-1:0] == IDX_W'(gi)) begin
          regs_reg[gi] <= bus.i_rx_byte;
        end
      end
    end
  endgenerate

  assign bus.o_tx_frame       = frame_reg;
  assign bus.o_tx_frame_valid = valid_reg;
  assign bus.o_busy           = busy_reg;
  assign bus.o_err_cnt        = err_reg;

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Bench for spi_cmd_handler: table of command bytes with expected busy/error
// state, a frame scoreboard popped on each valid pulse, and hand sequences
// for latency, abort, simultaneous abort, async reset and saturation.
`timescale 1ns/1ps
module tb_spi_cmd_handler;

  logic clk_12MHz = 1'b0;
  logic i_rst_n;

  always #5 clk_12MHz = ~clk_12MHz;

  spi_cmd_handler_if bus ();

  spi_cmd_handler dut (
    .clk_12MHz (clk_12MHz),
    .i_rst_n   (i_rst_n),
    .bus       (bus)
  );

  localparam logic [39:0] ID = 40'h5925A2B012;

  typedef struct {
    logic [7:0]  b;
    logic        busy;
    logic [7:0]  err;
    logic        has_frame;
    logic [39:0] frame;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] exp_q [$];
  vec_t        vecs  [$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected frame.
  always @(negedge clk_12MHz) begin
    if (i_rst_n === 1'b1 && bus.o_tx_frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_valid: got frame %h, expected no pulse", bus.o_tx_frame);
      end else begin
        check("frame", bus.o_tx_frame, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk_12MHz);
    bus.i_rx_byte = b;
    bus.i_rx_tgl  = ~bus.i_rx_tgl;
    repeat (7) @(negedge clk_12MHz);
  endtask

  task automatic cs_pulse();
    @(negedge clk_12MHz);
    bus.i_spi_cs = 1'b1;
    repeat (6) @(negedge clk_12MHz);
    bus.i_spi_cs = 1'b0;
    repeat (6) @(negedge clk_12MHz);
  endtask

  initial begin
    bus.i_rx_byte = 8'h00;
    bus.i_rx_tgl  = 1'b0;
    bus.i_spi_cs  = 1'b0;
    i_rst_n       = 1'b0;
    repeat (3) @(negedge clk_12MHz);
    check("rst_frame", bus.o_tx_frame, 40'h0);
    check("rst_valid", 40'(bus.o_tx_frame_valid), 40'h0);
    check("rst_busy",  40'(bus.o_busy), 40'h0);
    check("rst_err",   40'(bus.o_err_cnt), 40'h0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk_12MHz);

    // READ_ID latency: frame after 3 edges, valid pulse exactly after edge 4.
    exp_q.push_back(ID);
    bus.i_rx_byte = 8'h01;
    bus.i_rx_tgl  = ~bus.i_rx_tgl;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_12MHz);
      check($sformatf("lat_valid_c%0d", k), 40'(bus.o_tx_frame_valid), 40'((k == 4) ? 1 : 0));
      if (k == 2) check("lat_frame_c2", bus.o_tx_frame, 40'h0);
      if (k == 3) check("lat_frame_c3", bus.o_tx_frame, ID);
    end
    repeat (2) @(negedge clk_12MHz);

    // Table: byte, busy after, err after, frame expected.
    vecs.push_back('{8'h02, 1'b1, 8'd0, 1'b0, 40'h0});
    vecs.push_back('{8'h05, 1'b1, 8'd0, 1'b0, 40'h0});
    vecs.push_back('{8'hC3, 1'b0, 8'd0, 1'b0, 40'h0});
    vecs.push_back('{8'h03, 1'b1, 8'd0, 1'b0, 40'h0});
    vecs.push_back('{8'h05, 1'b0, 8'd0, 1'b1, 40'h0305C30000});
    vecs.push_back('{8'h00, 1'b0, 8'd0, 1'b0, 40'h0});
    vecs.push_back('{8'h01, 1'b0, 8'd0, 1'b1, ID});
    vecs.push_back('{8'h7F, 1'b0, 8'd1, 1'b0, 40'h0});
    vecs.push_back('{8'h02, 1'b1, 8'd1, 1'b0, 40'h0});
    vecs.push_back('{8'h09, 1'b1, 8'd1, 1'b0, 40'h0});
    vecs.push_back('{8'h11, 1'b0, 8'd2, 1'b0, 40'h0});
    vecs.push_back('{8'h03, 1'b1, 8'd2, 1'b0, 40'h0});
    vecs.push_back('{8'h05, 1'b0, 8'd2, 1'b1, 40'h0305C30200});
    vecs.push_back('{8'h03, 1'b1, 8'd2, 1'b0, 40'h0});
    vecs.push_back('{8'h09, 1'b0, 8'd3, 1'b1, 40'h0309000200});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].has_frame) exp_q.push_back(vecs[i].frame);
      send(vecs[i].b);
      check($sformatf("v%0d_busy", i), 40'(bus.o_busy), 40'(vecs[i].busy));
      check($sformatf("v%0d_err", i),  40'(bus.o_err_cnt), 40'(vecs[i].err));
    end

    // Abort a write after the address byte.
    send(8'h02);
    send(8'h04);
    check("abort_busy_pre", 40'(bus.o_busy), 40'h1);
    cs_pulse();
    check("abort_busy", 40'(bus.o_busy), 40'h0);
    check("abort_err",  40'(bus.o_err_cnt), 40'd3);
    send(8'h03);
    exp_q.push_back(40'h0304000300);
    send(8'h04);

    // CS rise and a byte in the same cycle: the byte must be discarded.
    send(8'h02);
    @(negedge clk_12MHz);
    bus.i_rx_byte = 8'h05;
    bus.i_rx_tgl  = ~bus.i_rx_tgl;
    bus.i_spi_cs  = 1'b1;
    repeat (6) @(negedge clk_12MHz);
    bus.i_spi_cs  = 1'b0;
    repeat (6) @(negedge clk_12MHz);
    check("simul_busy", 40'(bus.o_busy), 40'h0);
    check("simul_err",  40'(bus.o_err_cnt), 40'd3);
    send(8'h03);
    exp_q.push_back(40'h0305C30300);
    send(8'h05);

    // Async reset in the middle of a write.
    send(8'h02);
    send(8'h05);
    check("mid_busy", 40'(bus.o_busy), 40'h1);
    @(negedge clk_12MHz);
    #2;
    i_rst_n      = 1'b0;
    bus.i_rx_tgl = 1'b0;
    #1;
    check("arst_frame", bus.o_tx_frame, 40'h0);
    check("arst_valid", 40'(bus.o_tx_frame_valid), 40'h0);
    check("arst_busy",  40'(bus.o_busy), 40'h0);
    check("arst_err",   40'(bus.o_err_cnt), 40'h0);
    repeat (3) @(negedge clk_12MHz);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk_12MHz);
    send(8'h03);
    exp_q.push_back(40'h0305000000);
    send(8'h05);

    // Error counter saturation.
    for (int k = 1; k <= 300; k++) begin
      send(8'h7F);
      check($sformatf("sat_%0d", k), 40'(bus.o_err_cnt), 40'((k > 255) ? 255 : k));
    end

    repeat (4) @(negedge clk_12MHz);
    check("frames_left", 40'(exp_q.size()), 40'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
